// File: rtl/global_buffer_banked.sv
// Banked on-chip buffer: one byte-masked write port, one read port with single reads and self-sequencing bursts; optional GBUF_FWD_EN read-during-write forwarding.
// Latency: read issued at edge T returns rd_data/rd_valid after edge T+1; bursts stream one word per cycle after a one-cycle start-up.
// Backpressure: none downstream; single reads and new bursts are dropped while a burst is active, writes are always accepted.
`timescale 1ns/1ps
module global_buffer_banked #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 11,
    parameter int NUM_BANKS = 4,
    parameter int BANK_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BANK_BITS-1:0]   wr_bank,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic [DATA_BITS/8-1:0] wr_be,
    input  logic                   rd_en,
    input  logic [BANK_BITS-1:0]   rd_bank,
    input  logic [ADDR_BITS-1:0]   rd_addr,
    input  logic                   burst_start,
    input  logic [BANK_BITS-1:0]   burst_bank,
    input  logic [ADDR_BITS-1:0]   burst_addr,
    input  logic [ADDR_BITS:0]     burst_len,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   burst_busy,
    output logic                   burst_done
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int LANES = DATA_BITS / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [BANK_BITS-1:0]   bst_bank_q, bst_bank_d;
    logic [ADDR_BITS-1:0]   bst_addr_q, bst_addr_d;
    logic [ADDR_BITS:0]     bst_cnt_q, bst_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [BANK_BITS-1:0]   s1_bank_q, s1_bank_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   burst_req;
    logic                   single_acc;
    logic                   iss_vld;
    logic [BANK_BITS-1:0]   iss_bank;
    logic [ADDR_BITS-1:0]   iss_addr;
    logic [DATA_BITS-1:0]   s1_word;
    logic [DATA_BITS-1:0]   bank_out [NUM_BANKS];

    // busy_q lags the FSM by one cycle, so both terms are needed to keep
    // the read port exclusive to the burst from acceptance to the last word.
    always_comb begin
        burst_req  = burst_start && (state_q == IDLE) && !busy_q;
        single_acc = rd_en && !burst_start && (state_q == IDLE) && !busy_q;
        iss_vld    = (state_q == ISSUE) || single_acc;
        iss_bank   = (state_q == ISSUE) ? bst_bank_q : rd_bank;
        iss_addr   = (state_q == ISSUE) ? bst_addr_q : rd_addr;
    end

    always_comb begin
        state_d    = state_q;
        bst_bank_d = bst_bank_q;
        bst_addr_d = bst_addr_q;
        bst_cnt_d  = bst_cnt_q;
        busy_d     = (state_q != IDLE);
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_req) begin
                    if (burst_len != '0) begin
                        state_d    = ISSUE;
                        bst_bank_d = burst_bank;
                        bst_addr_d = burst_addr;
                        bst_cnt_d  = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                bst_addr_d = bst_addr_q + 1'b1;
                bst_cnt_d  = bst_cnt_q - 1'b1;
                if (bst_cnt_q == (ADDR_BITS+1)'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_bank_q == BANK_BITS'(b)) begin
                s1_word = bank_out[b];
            end
        end
        s1_vld_d   = iss_vld;
        s1_bank_d  = iss_bank;
        rd_valid_d = s1_vld_q;
        rd_data_d  = s1_vld_q ? s1_word : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bst_bank_q <= '0;
            bst_addr_q <= '0;
            bst_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_bank_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bst_bank_q <= bst_bank_d;
            bst_addr_q <= bst_addr_d;
            bst_cnt_q  <= bst_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_vld_q   <= s1_vld_d;
            s1_bank_q  <= s1_bank_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_BITS-1:0] mem [DEPTH];
        logic [DATA_BITS-1:0] rd_d;
        logic [DATA_BITS-1:0] rd_q;
        logic                 wr_sel;
        logic                 rd_sel;

        assign wr_sel = wr_en && (wr_bank == BANK_BITS'(b));
        assign rd_sel = iss_vld && (iss_bank == BANK_BITS'(b));

`ifdef GBUF_FWD_EN
        always_comb begin
            rd_d = mem[iss_addr];
            if (wr_sel && (wr_addr == iss_addr)) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wr_be[k]) rd_d[k*8 +: 8] = wr_data[k*8 +: 8];
                end
            end
        end
`else
        assign rd_d = mem[iss_addr];
`endif

        // Array and read register are not reset so they map onto block RAM.
        always_ff @(posedge clk) begin
            if (wr_sel) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wr_be[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
            if (rd_sel) rd_q <= rd_d;
        end

        assign bank_out[b] = rd_q;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign burst_busy = busy_q;
    assign burst_done = done_q;
endmodule

// File: tb/tb_global_buffer_banked.sv
// Bench for global_buffer_banked: table-driven write/read vectors plus hand sequences for bursts, collisions, forwarding and mid-burst reset.
`timescale 1ns/1ps
module tb_global_buffer_banked;
    logic        clk, rst;
    logic        wr_en, rd_en, burst_start;
    logic [2:0]  wr_bank, rd_bank, burst_bank;
    logic [10:0] wr_addr, rd_addr, burst_addr;
    logic [11:0] burst_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        rd_valid, burst_busy, burst_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    global_buffer_banked dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .burst_start(burst_start), .burst_bank(burst_bank), .burst_addr(burst_addr), .burst_len(burst_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .burst_busy(burst_busy), .burst_done(burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  bank;
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] b, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] b, input logic [10:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_bank = b; rd_addr = a;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_burst(input logic [2:0] b, input logic [10:0] a, input logic [11:0] len);
        burst_start = 1'b1; burst_bank = b; burst_addr = a; burst_len = len;
        tick();
        burst_start = 1'b0;
    endtask

    // Samples n cycles starting with the current one; optionally injects an
    // ignored single read and burst request while a burst is running.
    task automatic watch(input int n, input bit inject, output int busy_n, output int valid_n,
                         output int done_n, output int first_valid, output int done_idx, output int done_w_valid);
        busy_n = 0; valid_n = 0; done_n = 0; first_valid = -1; done_idx = -1; done_w_valid = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (burst_busy) busy_n++;
            if (rd_valid) begin
                valid_n++;
                if (first_valid < 0) first_valid = i;
            end
            if (burst_done) begin
                done_n++;
                done_idx = i;
                done_w_valid = int'(rd_valid);
            end
            if (inject && i == 2) begin
                rd_en = 1'b1; rd_bank = 3'd0; rd_addr = 11'd7;
            end
            if (inject && i == 3) begin
                rd_en = 1'b0;
                burst_start = 1'b1; burst_bank = 3'd1; burst_addr = 11'd2046; burst_len = 12'd2;
            end
            if (inject && i == 4) burst_start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rd_data", rd_data, mon_e);
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rd_valid: got rd_valid=1 data %h expected no read", rd_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int bn, vn, dn, fv, di, dwv;
        vecs[0] = '{3'd2, 11'd5,    32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
        vecs[1] = '{3'd0, 11'd7,    32'h11223344, 4'hF,    32'h11223344};
        vecs[2] = '{3'd0, 11'd7,    32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
        vecs[3] = '{3'd3, 11'd2047, 32'h12345678, 4'hF,    32'h12345678};
        vecs[4] = '{3'd3, 11'd2047, 32'hFFFFFFFF, 4'b1000, 32'hFF345678};
        vecs[5] = '{3'd1, 11'd5,    32'h00000000, 4'hF,    32'h00000000};
        vecs[6] = '{3'd5, 11'd5,    32'hCAFEBABE, 4'hF,    32'h00000000};
        vecs[7] = '{3'd1, 11'd5,    32'h77777777, 4'h0,    32'h00000000};
        vecs[8] = '{3'd2, 11'd5,    32'h00000000, 4'b0110, 32'hDE0000EF};
        vecs[9] = '{3'd7, 11'd0,    32'h12121212, 4'hF,    32'h00000000};

        rst = 1'b1;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        burst_start = 1'b0; burst_bank = '0; burst_addr = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_burst_busy", 32'(burst_busy), 32'd0);
        check("reset_burst_done", 32'(burst_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].bank, vecs[i].addr, vecs[i].data, vecs[i].be);
            rd(vecs[i].bank, vecs[i].addr, vecs[i].exp);
        end
        drain("table_drain");

        // Burst across the top of the bank: 2046, 2047, 0, 1.
        wr(3'd1, 11'd2046, 32'd1, 4'hF);
        wr(3'd1, 11'd2047, 32'd2, 4'hF);
        wr(3'd1, 11'd0,    32'd3, 4'hF);
        wr(3'd1, 11'd1,    32'd4, 4'hF);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        start_burst(3'd1, 11'd2046, 12'd4);
        watch(10, 1'b1, bn, vn, dn, fv, di, dwv);
        check("wrap_busy_cycles", 32'(bn), 32'd5);
        check("wrap_valid_cycles", 32'(vn), 32'd4);
        check("wrap_first_valid", 32'(fv), 32'd2);
        check("wrap_done_count", 32'(dn), 32'd1);
        check("wrap_done_idx", 32'(di), 32'd5);
        check("wrap_done_with_valid", 32'(dwv), 32'd1);
        drain("wrap_drain");

        // Zero-length burst together with a single read: only burst_done.
        rd_en = 1'b1; rd_bank = 3'd0; rd_addr = 11'd7;
        start_burst(3'd0, 11'd7, 12'd0);
        rd_en = 1'b0;
        watch(4, 1'b0, bn, vn, dn, fv, di, dwv);
        check("zlen_done_count", 32'(dn), 32'd1);
        check("zlen_valid_cycles", 32'(vn), 32'd0);
        check("zlen_busy_cycles", 32'(bn), 32'd0);

        // Same-cycle write and read of one address.
        wr(3'd0, 11'd100, 32'd0, 4'hF);
        wr_en = 1'b1; wr_bank = 3'd0; wr_addr = 11'd100; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_bank = 3'd0; rd_addr = 11'd100;
`ifdef GBUF_FWD_EN
        exp_q.push_back(32'hCAFEF00D);
`else
        exp_q.push_back(32'h00000000);
`endif
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(3'd0, 11'd100, 32'hCAFEF00D);
        drain("fwd_drain");

        // Reset while the third word of an 8-word burst is on the output.
        for (int i = 0; i < 8; i++) wr(3'd2, 11'(10 + i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i));
        start_burst(3'd2, 11'd10, 12'd8);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("midrst_words_seen", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_rd_data", rd_data, 32'd0);
        check("midrst_busy", 32'(burst_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        watch(10, 1'b0, bn, vn, dn, fv, di, dwv);
        check("midrst_no_done", 32'(dn), 32'd0);
        check("midrst_no_valid", 32'(vn), 32'd0);
        for (int i = 3; i < 6; i++) exp_q.push_back(32'h100 + 32'(i));
        tick();
        start_burst(3'd2, 11'd13, 12'd3);
        watch(8, 1'b0, bn, vn, dn, fv, di, dwv);
        check("post_rst_done_count", 32'(dn), 32'd1);
        check("post_rst_valid_cycles", 32'(vn), 32'd3);
        check("post_rst_busy_cycles", 32'(bn), 32'd4);
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
